// File: rtl/axi_revision_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axi_revision_reader                                              |
// | Purpose : AXI4-Lite read-only master that fetches the seven build-revision |
// |           registers (major, minor, build, rc, date, type, subtype) from    |
// |           the revision slave and presents them as latched parallel values. |
// | Ports   : AXI_ACLK / AXI_ARESETN  clock, async active-low reset            |
// |           start                   request a (re)read, ignored while busy   |
// |           M_AXI_AR* / M_AXI_R*    AXI4-Lite read channels (master side)    |
// |           rev_* / rtl_* / date_*  latched register values, decoded date    |
// |           busy valid error        sequence status                          |
// |           error_index stall       first failing index, stuck-transaction   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module axi_revision_reader #(
  parameter int unsigned                 M_AXI_ADDR_WIDTH = 32,
  parameter logic [M_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
  parameter bit                          AUTO_START       = 1'b1,
  parameter int unsigned                 STALL_CYCLES     = 1024
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESETN,
  input  logic                        start,
  output logic [M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                        M_AXI_ARVALID,
  output logic [2:0]                  M_AXI_ARPROT,
  input  logic                        M_AXI_ARREADY,
  input  logic [31:0]                 M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  output logic [31:0]                 rev_major,
  output logic [31:0]                 rev_minor,
  output logic [31:0]                 rev_build,
  output logic [31:0]                 rev_rcand,
  output logic [31:0]                 rtl_type,
  output logic [31:0]                 rtl_subtype,
  output logic [15:0]                 date_year,
  output logic [7:0]                  date_day,
  output logic [7:0]                  date_month,
  output logic                        busy,
  output logic                        valid,
  output logic                        error,
  output logic [2:0]                  error_index,
  output logic                        stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [2:0] c_last_index = 3'd6;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_index;
  logic [2:0] w_index_inc;
  logic       r_auto;        // one-shot request armed by reset release
  logic       w_start_seq;
  logic       w_ar_hs;
  logic       w_r_hs;
  logic       w_resp_err;
  logic       w_last;
  logic       w_enter_addr;

  assign M_AXI_ARPROT = 3'b000;

  assign w_start_seq  = (r_state == S_IDLE) && (start || r_auto);
  assign w_ar_hs      = M_AXI_ARVALID && M_AXI_ARREADY;
  assign w_r_hs       = M_AXI_RREADY && M_AXI_RVALID;
  assign w_resp_err   = (M_AXI_RRESP != 2'b00);
  assign w_last       = (r_index == c_last_index);
  assign w_index_inc  = r_index + 3'd1;
  assign w_enter_addr = (w_next_state == S_ADDR) && (r_state != S_ADDR);

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) r_state <= S_IDLE;
    else              r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_seq) w_next_state = S_ADDR;
      S_ADDR:  if (w_ar_hs)     w_next_state = S_DATA;
      S_DATA:  if (w_r_hs)      w_next_state = w_last ? S_IDLE : S_ADDR;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_auto        <= AUTO_START;
      r_index       <= 3'd0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rev_major     <= '0;
      rev_minor     <= '0;
      rev_build     <= '0;
      rev_rcand     <= '0;
      rtl_type      <= '0;
      rtl_subtype   <= '0;
      date_year     <= '0;
      date_day      <= '0;
      date_month    <= '0;
      busy          <= 1'b0;
      valid         <= 1'b0;
      error         <= 1'b0;
      error_index   <= 3'd0;
    end else begin
      // The auto request only ever applies to the first clock after release.
      r_auto <= 1'b0;

      if (w_start_seq) begin
        r_index       <= 3'd0;
        busy          <= 1'b1;
        valid         <= 1'b0;
        error         <= 1'b0;
        error_index   <= 3'd0;
        M_AXI_ARADDR  <= BASE_ADDR;
        M_AXI_ARVALID <= 1'b1;
      end

      if (r_state == S_ADDR && w_ar_hs) begin
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b1;
      end

      if (r_state == S_DATA && w_r_hs) begin
        case (r_index)
          3'd0: rev_major   <= M_AXI_RDATA;
          3'd1: rev_minor   <= M_AXI_RDATA;
          3'd2: rev_build   <= M_AXI_RDATA;
          3'd3: rev_rcand   <= M_AXI_RDATA;
          3'd4: begin
            date_year  <= M_AXI_RDATA[15:0];
            date_day   <= M_AXI_RDATA[23:16];
            date_month <= M_AXI_RDATA[31:24];
          end
          3'd5: rtl_type    <= M_AXI_RDATA;
          3'd6: rtl_subtype <= M_AXI_RDATA;
          default: ;
        endcase

        // Only the first failing register is recorded; data is kept anyway.
        if (w_resp_err && !error) begin
          error       <= 1'b1;
          error_index <= r_index;
        end

        M_AXI_RREADY <= 1'b0;
        if (w_last) begin
          busy  <= 1'b0;
          valid <= ~(error | w_resp_err);
        end else begin
          r_index       <= w_index_inc;
          M_AXI_ARADDR  <= BASE_ADDR + M_AXI_ADDR_WIDTH'({w_index_inc, 2'b00});
          M_AXI_ARVALID <= 1'b1;
        end
      end
    end
  end

  generate
    if (STALL_CYCLES != 0) begin : g_stall
      localparam int unsigned            c_cnt_w     = $clog2(STALL_CYCLES + 1);
      localparam logic [c_cnt_w-1:0]     c_stall_cnt = c_cnt_w'(STALL_CYCLES);

      logic [c_cnt_w-1:0] r_cnt;
      logic [c_cnt_w-1:0] w_cnt_inc;
      logic               r_stall;

      assign w_cnt_inc = r_cnt + 1'b1;

      // Per-transaction wait counter; it saturates at the threshold so it can
      // never wrap and the flag stays sticky until the next sequence start.
      always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
          r_cnt   <= '0;
          r_stall <= 1'b0;
        end else if (w_enter_addr) begin
          r_cnt <= '0;
          if (w_start_seq) r_stall <= 1'b0;
        end else if (r_state != S_IDLE && r_cnt != c_stall_cnt) begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == c_stall_cnt) r_stall <= 1'b1;
        end
      end

      assign stall = r_stall;
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
